// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: widths, FSM states,
// opcode/funct3 codes and default reset PC / halt register.
package seq_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [XLEN-1:0]   DEF_RESET_PC = 32'h0000_0000;
    localparam logic [REG_AW-1:0] DEF_HALT_REG = 5'd30;

endpackage

// File: rtl/m_imm_ext.sv
// Sign-extended I/B/J immediates from an instruction word. The opcode field
// carries no immediate bits, so only bits [31:7] are taken.
module m_imm_ext
    import seq_pkg::*;
(
    input  logic [XLEN-1:7] i_inst,
    output logic [XLEN-1:0] o_imm_i,
    output logic [XLEN-1:0] o_imm_b,
    output logic [XLEN-1:0] o_imm_j
);

    assign o_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign o_imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign o_imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

endmodule

// File: rtl/m_seq_ctrl.sv
// Multi-cycle sequencer: owns PC/IR, steps FETCH/DECODE/EXEC/WB, decodes
// ADD/SUB/ADDI/BEQ/BNE/JAL and drives the RF/ALU controls of the datapath.
module m_seq_ctrl
    import seq_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC = DEF_RESET_PC,
    parameter logic [REG_AW-1:0] HALT_REG = DEF_HALT_REG
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [XLEN-1:0]   w_inst,
    input  logic              w_br_eq,
    output logic [XLEN-1:0]   w_pc,
    output logic [XLEN-1:0]   w_ir,
    output logic [XLEN-1:0]   w_imm,
    output logic              w_alu_src_imm,
    output logic              w_alu_sub,
    output logic              w_wb_sel_pc4,
    output logic              w_rf_we,
    output logic [REG_AW-1:0] w_rf_waddr,
    output logic              w_halted,
    output logic              w_illegal,
    output logic [ST_W-1:0]   w_state,
    output logic [XLEN-1:0]   w_cycle_cnt,
    output logic [XLEN-1:0]   w_instret
);

    state_e              r_state;
    state_e              w_next_state;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_ir;
    logic                r_br_taken;
    logic [XLEN-1:0]     r_target;
    logic                r_halted;
    logic                r_illegal;
    logic [XLEN-1:0]     r_cycle_cnt;
    logic [XLEN-1:0]     r_instret;

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [REG_AW-1:0]   w_rd;
    logic [XLEN-1:0]     w_imm_i;
    logic [XLEN-1:0]     w_imm_b;
    logic [XLEN-1:0]     w_imm_j;
    logic                w_is_op;
    logic                w_is_opimm;
    logic                w_is_br;
    logic                w_is_jal;
    logic                w_take;
    logic [XLEN-1:0]     w_pc_plus4;
    logic [XLEN-1:0]     w_tgt;
    logic [XLEN-1:0]     w_next_pc;
    logic                w_dec_illegal;
    logic                w_writes;
    logic                w_halt_write;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_rd     = r_ir[11:7];

    m_imm_ext u_imm_ext (
        .i_inst  (r_ir[XLEN-1:7]),
        .o_imm_i (w_imm_i),
        .o_imm_b (w_imm_b),
        .o_imm_j (w_imm_j)
    );

    // Instruction class decode; unsupported opcode/funct3 leaves all flags low.
    always_comb begin
        w_is_op    = 1'b0;
        w_is_opimm = 1'b0;
        w_is_br    = 1'b0;
        w_is_jal   = 1'b0;
        case (w_opcode)
            OPC_OP:     w_is_op    = (w_funct3 == F3_ADD);
            OPC_OPIMM:  w_is_opimm = (w_funct3 == F3_ADD);
            OPC_BRANCH: w_is_br    = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE);
            OPC_JAL:    w_is_jal   = 1'b1;
            default:    ;
        endcase
    end

    assign w_take        = w_is_jal ||
                           (w_is_br && ((w_funct3 == F3_BNE) ? !w_br_eq : w_br_eq));
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_tgt         = r_pc + (w_is_jal ? w_imm_j : w_imm_b);
    assign w_next_pc     = w_take ? w_tgt : w_pc_plus4;
    assign w_dec_illegal = !(w_is_op || w_is_opimm || w_is_br || w_is_jal) ||
                           (w_next_pc[1:0] != 2'b00);
    assign w_writes      = (w_is_op || w_is_opimm || w_is_jal) && (w_rd != 5'd0);
    assign w_halt_write  = w_writes && (w_rd == HALT_REG);

    // State register.
    always_ff @(posedge w_clk) begin
        if (w_rst) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = w_dec_illegal ? ST_HALT : ST_WB;
            ST_WB:     w_next_state = w_halt_write  ? ST_HALT : ST_FETCH;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Outputs; selects follow the IR so they stay stable across EXEC and WB.
    always_comb begin
        w_rf_we       = 1'b0;
        w_alu_src_imm = w_is_opimm;
        w_alu_sub     = w_is_op && r_ir[30];
        w_wb_sel_pc4  = w_is_jal;
        if (r_state == ST_WB) w_rf_we = w_writes;
    end

    // PC, IR, branch decision and counters.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_br_taken  <= 1'b0;
            r_target    <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (r_state != ST_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_next_state == ST_HALT) r_halted <= 1'b1;
            case (r_state)
                ST_DECODE: r_ir <= w_inst;
                ST_EXEC: begin
                    r_br_taken <= w_take;
                    r_target   <= w_tgt;
                    if (w_dec_illegal) r_illegal <= 1'b1;
                end
                ST_WB: begin
                    r_pc      <= r_br_taken ? r_target : w_pc_plus4;
                    r_instret <= r_instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_pc        = r_pc;
    assign w_ir        = r_ir;
    assign w_imm       = w_imm_i;
    assign w_rf_waddr  = w_rd;
    assign w_halted    = r_halted;
    assign w_illegal   = r_illegal;
    assign w_state     = r_state;
    assign w_cycle_cnt = r_cycle_cnt;
    assign w_instret   = r_instret;

endmodule

// File: tb/tb_m_seq_ctrl.sv
// Directed bench for m_seq_ctrl with a synchronous 1-cycle instruction memory.
module tb_m_seq_ctrl;

    logic        w_clk;
    logic        w_rst;
    logic [31:0] w_inst;
    logic        w_br_eq;
    logic [31:0] w_pc;
    logic [31:0] w_ir;
    logic [31:0] w_imm;
    logic        w_alu_src_imm;
    logic        w_alu_sub;
    logic        w_wb_sel_pc4;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic        w_halted;
    logic        w_illegal;
    logic [2:0]  w_state;
    logic [31:0] w_cycle_cnt;
    logic [31:0] w_instret;

    logic [31:0] imem [0:63];

    int          n_chk;
    int          n_fail;

    int          obs_we_cnt;
    logic [4:0]  obs_waddr;
    logic        obs_src_imm;
    logic        obs_sub;
    logic        obs_pc4;
    logic [31:0] obs_imm;
    logic [2:0]  obs_state;

    m_seq_ctrl dut (
        .w_clk         (w_clk),
        .w_rst         (w_rst),
        .w_inst        (w_inst),
        .w_br_eq       (w_br_eq),
        .w_pc          (w_pc),
        .w_ir          (w_ir),
        .w_imm         (w_imm),
        .w_alu_src_imm (w_alu_src_imm),
        .w_alu_sub     (w_alu_sub),
        .w_wb_sel_pc4  (w_wb_sel_pc4),
        .w_rf_we       (w_rf_we),
        .w_rf_waddr    (w_rf_waddr),
        .w_halted      (w_halted),
        .w_illegal     (w_illegal),
        .w_state       (w_state),
        .w_cycle_cnt   (w_cycle_cnt),
        .w_instret     (w_instret)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) w_inst <= imem[w_pc[7:2]];

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Runs one 4-cycle instruction from FETCH, capturing the WB-cycle controls.
    task automatic exec_instr(input logic br_eq);
        w_br_eq    = br_eq;
        obs_we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (w_rf_we === 1'b1) obs_we_cnt++;
            if (i == 3) begin
                obs_waddr   = w_rf_waddr;
                obs_src_imm = w_alu_src_imm;
                obs_sub     = w_alu_sub;
                obs_pc4     = w_wb_sel_pc4;
                obs_imm     = w_imm;
                obs_state   = w_state;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        w_rst = 1'b1;
        tick();
        tick();
        w_rst = 1'b0;
        n_chk++; if (w_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", w_state); end
        n_chk++; if (w_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %0h exp 0", w_pc); end
        n_chk++; if (w_rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", w_rf_we); end
        n_chk++; if (w_cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cyc: got %0d exp 0", w_cycle_cnt); end
        n_chk++; if (w_instret !== 32'd0) begin n_fail++; $display("FAIL reset_ret: got %0d exp 0", w_instret); end
        n_chk++; if (w_ir !== 32'd0) begin n_fail++; $display("FAIL reset_ir: got %0h exp 0", w_ir); end
        n_chk++; if ({w_halted, w_illegal, w_alu_src_imm, w_alu_sub, w_wb_sel_pc4} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b exp 00000",
                  {w_halted, w_illegal, w_alu_src_imm, w_alu_sub, w_wb_sel_pc4}); end
    endtask

    task automatic test_alu_seq();
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 1 || obs_waddr !== 5'd1 || obs_src_imm !== 1'b1)
            begin n_fail++; $display("FAIL addi1_wb: got we=%0d wa=%0d imm=%b exp 1/1/1", obs_we_cnt, obs_waddr, obs_src_imm); end
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 1 || obs_waddr !== 5'd2 || obs_src_imm !== 1'b1)
            begin n_fail++; $display("FAIL addi2_wb: got we=%0d wa=%0d imm=%b exp 1/2/1", obs_we_cnt, obs_waddr, obs_src_imm); end
        n_chk++; if (obs_imm !== 32'd7) begin n_fail++; $display("FAIL addi2_imm: got %0h exp 7", obs_imm); end
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 1 || obs_waddr !== 5'd3 || obs_src_imm !== 1'b0 || obs_sub !== 1'b0)
            begin n_fail++; $display("FAIL add_wb: got we=%0d wa=%0d imm=%b sub=%b exp 1/3/0/0", obs_we_cnt, obs_waddr, obs_src_imm, obs_sub); end
        n_chk++; if (w_pc !== 32'd12) begin n_fail++; $display("FAIL alu_pc: got %0d exp 12", w_pc); end
        n_chk++; if (w_instret !== 32'd3) begin n_fail++; $display("FAIL alu_ret: got %0d exp 3", w_instret); end
        n_chk++; if (w_cycle_cnt !== 32'd12) begin n_fail++; $display("FAIL alu_cyc: got %0d exp 12", w_cycle_cnt); end
    endtask

    task automatic test_branch_taken();
        exec_instr(1'b1);
        n_chk++; if (obs_we_cnt !== 0) begin n_fail++; $display("FAIL beq_t_we: got %0d exp 0", obs_we_cnt); end
        n_chk++; if (w_pc !== 32'd20) begin n_fail++; $display("FAIL beq_t_pc: got %0d exp 20", w_pc); end
    endtask

    task automatic test_jal();
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 1 || obs_waddr !== 5'd1 || obs_pc4 !== 1'b1)
            begin n_fail++; $display("FAIL jal_wb: got we=%0d wa=%0d pc4=%b exp 1/1/1", obs_we_cnt, obs_waddr, obs_pc4); end
        n_chk++; if (obs_imm !== 32'hFFFF_FFF5) begin n_fail++; $display("FAIL jal_iimm: got %0h exp fffffff5", obs_imm); end
        n_chk++; if (w_pc !== 32'd8) begin n_fail++; $display("FAIL jal_pc: got %0d exp 8", w_pc); end
        exec_instr(1'b0);
        n_chk++; if (w_pc !== 32'd12) begin n_fail++; $display("FAIL readd_pc: got %0d exp 12", w_pc); end
    endtask

    task automatic test_branch_not_taken();
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 0) begin n_fail++; $display("FAIL beq_nt_we: got %0d exp 0", obs_we_cnt); end
        n_chk++; if (w_pc !== 32'd16) begin n_fail++; $display("FAIL beq_nt_pc: got %0d exp 16", w_pc); end
    endtask

    task automatic test_bne();
        exec_instr(1'b0);
        n_chk++; if (w_pc !== 32'd24) begin n_fail++; $display("FAIL bne_pc: got %0d exp 24", w_pc); end
    endtask

    task automatic test_jal_x0();
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 0 || obs_pc4 !== 1'b1)
            begin n_fail++; $display("FAIL jalx0_wb: got we=%0d pc4=%b exp 0/1", obs_we_cnt, obs_pc4); end
        n_chk++; if (w_pc !== 32'd32) begin n_fail++; $display("FAIL jalx0_pc: got %0d exp 32", w_pc); end
    endtask

    task automatic test_halt();
        int we_after;
        exec_instr(1'b0);
        n_chk++; if (obs_we_cnt !== 1 || obs_waddr !== 5'd30)
            begin n_fail++; $display("FAIL halt_wb: got we=%0d wa=%0d exp 1/30", obs_we_cnt, obs_waddr); end
        n_chk++; if (w_state !== 3'd4 || w_halted !== 1'b1 || w_illegal !== 1'b0)
            begin n_fail++; $display("FAIL halt_flags: got st=%0d h=%b il=%b exp 4/1/0", w_state, w_halted, w_illegal); end
        we_after = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_rf_we !== 1'b0) we_after++;
        end
        n_chk++; if (w_pc !== 32'd36) begin n_fail++; $display("FAIL halt_pc: got %0d exp 36", w_pc); end
        n_chk++; if (w_instret !== 32'd10) begin n_fail++; $display("FAIL halt_ret: got %0d exp 10", w_instret); end
        n_chk++; if (w_cycle_cnt !== 32'd40) begin n_fail++; $display("FAIL halt_cyc: got %0d exp 40", w_cycle_cnt); end
        n_chk++; if (we_after !== 0 || w_halted !== 1'b1)
            begin n_fail++; $display("FAIL halt_hold: got we=%0d h=%b exp 0/1", we_after, w_halted); end
    endtask

    task automatic test_illegal();
        imem[0] = 32'h0000_0000;
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        exec_instr(1'b0);
        n_chk++; if (obs_state !== 3'd4) begin n_fail++; $display("FAIL ill_state: got %0d exp 4", obs_state); end
        n_chk++; if (w_illegal !== 1'b1 || w_halted !== 1'b1)
            begin n_fail++; $display("FAIL ill_flags: got il=%b h=%b exp 1/1", w_illegal, w_halted); end
        n_chk++; if (obs_we_cnt !== 0) begin n_fail++; $display("FAIL ill_we: got %0d exp 0", obs_we_cnt); end
        n_chk++; if (w_instret !== 32'd0) begin n_fail++; $display("FAIL ill_ret: got %0d exp 0", w_instret); end
        n_chk++; if (w_cycle_cnt !== 32'd3) begin n_fail++; $display("FAIL ill_cyc: got %0d exp 3", w_cycle_cnt); end
    endtask

    task automatic test_reset_midway();
        imem[0] = 32'h4020_8233;
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        tick();
        tick();
        n_chk++; if (w_state !== 3'd2 || w_alu_sub !== 1'b1 || w_ir !== 32'h4020_8233)
            begin n_fail++; $display("FAIL sub_exec: got st=%0d sub=%b ir=%0h exp 2/1/40208233", w_state, w_alu_sub, w_ir); end
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        n_chk++; if (w_state !== 3'd0 || w_pc !== 32'd0 || w_rf_we !== 1'b0)
            begin n_fail++; $display("FAIL rst_exec: got st=%0d pc=%0h we=%b exp 0/0/0", w_state, w_pc, w_rf_we); end
        n_chk++; if (w_cycle_cnt !== 32'd0 || w_instret !== 32'd0 || w_ir !== 32'd0 || w_illegal !== 1'b0)
            begin n_fail++; $display("FAIL rst_exec_cnt: got cyc=%0d ret=%0d ir=%0h il=%b exp 0/0/0/0",
                  w_cycle_cnt, w_instret, w_ir, w_illegal); end
        tick();
        tick();
        tick();
        n_chk++; if (w_state !== 3'd3 || w_rf_we !== 1'b1 || w_rf_waddr !== 5'd4)
            begin n_fail++; $display("FAIL sub_wb: got st=%0d we=%b wa=%0d exp 3/1/4", w_state, w_rf_we, w_rf_waddr); end
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        n_chk++; if (w_state !== 3'd0 || w_rf_we !== 1'b0 || w_pc !== 32'd0 || w_instret !== 32'd0)
            begin n_fail++; $display("FAIL rst_wb: got st=%0d we=%b pc=%0h ret=%0d exp 0/0/0/0", w_state, w_rf_we, w_pc, w_instret); end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        w_rst   = 1'b1;
        w_br_eq = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'h0050_0093; // addi x1,x0,5
        imem[1]  = 32'h0070_0113; // addi x2,x0,7
        imem[2]  = 32'h0020_81B3; // add  x3,x1,x2
        imem[3]  = 32'h0010_8463; // beq  x1,x1,+8
        imem[4]  = 32'h0020_9463; // bne  x1,x2,+8
        imem[5]  = 32'hFF5F_F0EF; // jal  x1,-12
        imem[6]  = 32'h0080_006F; // jal  x0,+8
        imem[8]  = 32'h0010_0F13; // addi x30,x0,1

        test_reset();
        test_alu_seq();
        test_branch_taken();
        test_jal();
        test_branch_not_taken();
        test_bne();
        test_jal_x0();
        test_halt();
        test_illegal();
        test_reset_midway();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
